// File: rtl/iobus_pkg.sv
// Shared definitions for the IO-bus UART transmitter: register map, STATUS
// bit layout and serializer state encoding.
package iobus_pkg;

    localparam logic [31:0] ADDR_TXDATA  = 32'h1100_0040;
    localparam logic [31:0] ADDR_STATUS  = 32'h1100_0044;
    localparam logic [31:0] ADDR_BAUDDIV = 32'h1100_0048;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // A divisor below 2 cannot form a bit time, so it is raised to 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy counter.
// Head entry is presented combinationally on pop_data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   push_ok,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Handshake: push and pop are single-cycle requests. A pop is taken when
    // the FIFO is non-empty; a push is taken when not full, or when full and
    // a pop is taken in the same cycle. push_ok reports whether push was taken.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign push_ok  = do_push;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge CLK) begin
        if (RST && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUDDIV registers on the CPU
// IO bus, a byte FIFO, and an 8N1 serializer with a programmable bit time.
module iobus_uart_tx
    import iobus_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int BAUD_DIV_RST = 868
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        TX_BUSY
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_push_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_t     state;
    logic          tx_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic [15:0]   div_lat;
    logic [15:0]   divisor;
    logic          ovf;
    logic          bit_end;
    logic [31:0]   status_word;
    logic          unused_out;

    assign wr_txdata  = IOBUS_WR && (IOBUS_ADDR == ADDR_TXDATA);
    assign wr_status  = IOBUS_WR && (IOBUS_ADDR == ADDR_STATUS);
    assign wr_baud    = IOBUS_WR && (IOBUS_ADDR == ADDR_BAUDDIV);
    assign unused_out = ^IOBUS_OUT[31:16];

    assign fifo_pop = (state == S_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (wr_txdata),
        .push_data (IOBUS_OUT[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .push_ok   (fifo_push_ok),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            divisor <= 16'(BAUD_DIV_RST);
            ovf     <= 1'b0;
        end else begin
            if (wr_baud) begin
                divisor <= clamp_div(IOBUS_OUT[15:0]);
            end
            // A dropped push outranks a simultaneous software clear.
            if (wr_txdata && !fifo_push_ok) begin
                ovf <= 1'b1;
            end else if (wr_status && IOBUS_OUT[ST_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bit_end = (baud_cnt == (div_lat - 16'd1));

    // Serializer. div_lat holds the bit time for the whole frame so BAUDDIV
    // writes only apply from the next IDLE-to-START transition.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            tx_q     <= 1'b1;
            shift_q  <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            div_lat  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q  <= fifo_dout;
                        div_lat  <= divisor;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= shift_q[0];
                        shift_q  <= {1'b0, shift_q[7:1]};
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign TX      = tx_q;
    assign TX_BUSY = (state != S_IDLE) || !fifo_empty;

    always_comb begin
        status_word                        = '0;
        status_word[ST_FULL]               = fifo_full;
        status_word[ST_EMPTY]              = fifo_empty;
        status_word[ST_BUSY]               = (state != S_IDLE);
        status_word[ST_OVF]                = ovf;
        status_word[ST_CNT_MSB:ST_CNT_LSB] = 7'(fifo_count);
    end

    // Unmapped addresses read as zero so the bus can OR peripherals together.
    always_comb begin
        IOBUS_IN = '0;
        case (IOBUS_ADDR)
            ADDR_STATUS:  IOBUS_IN = status_word;
            ADDR_BAUDDIV: IOBUS_IN = {16'b0, divisor};
            default:      IOBUS_IN = '0;
        endcase
    end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Directed bench for iobus_uart_tx: register access, frame timing, overflow,
// divisor handling, reset abort, decode and FIFO wrap.
module tb_iobus_uart_tx;
    import iobus_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        TX;
    logic        TX_BUSY;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         mon_en = 1'b0;
    int         mon_div = 2;
    int         frame_errs = 0;

    iobus_uart_tx #(
        .FIFO_DEPTH   (8),
        .BAUD_DIV_RST (868)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .TX         (TX),
        .TX_BUSY    (TX_BUSY)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
    endtask

    task automatic io_read(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        #1;
        d = IOBUS_IN;
        IOBUS_ADDR = '0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        io_read(a, d);
        check(tag, d, exp);
    endtask

    // Called in the first START cycle; checks every cycle of the 10 bits and
    // returns in the cycle after the stop bit. Optionally issues one bus write
    // at the first cycle of bit wr_bit.
    task automatic check_frame(input logic [7:0] b, input int div, input string tag,
                               input bit do_wr, input logic [31:0] wa,
                               input logic [31:0] wd, input int wr_bit);
        for (int k = 0; k < 10; k++) begin
            logic exp_bit;
            int   bad;
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            bad = 0;
            for (int c = 0; c < div; c++) begin
                bit drove;
                drove = 1'b0;
                if (do_wr && k == wr_bit && c == 0) begin
                    IOBUS_ADDR = wa;
                    IOBUS_OUT  = wd;
                    IOBUS_WR   = 1'b1;
                    drove      = 1'b1;
                end
                if (TX !== exp_bit) bad++;
                tick();
                if (drove) begin
                    IOBUS_WR   = 1'b0;
                    IOBUS_ADDR = '0;
                    IOBUS_OUT  = '0;
                end
            end
            check($sformatf("%s_bit%0d_bad_cycles", tag, k), bad, 0);
        end
    endtask

    // Polls STATUS until the serializer is in IDLE (the pop cycle between frames).
    task automatic wait_line_idle(input string tag);
        logic [31:0] s;
        int          n;
        bit          tmo;
        n   = 0;
        tmo = 1'b0;
        io_read(ADDR_STATUS, s);
        while (s[ST_BUSY]) begin
            tick();
            n++;
            if (n > 2000) begin
                tmo = 1'b1;
                break;
            end
            io_read(ADDR_STATUS, s);
        end
        check(tag, tmo, 1'b0);
    endtask

    // ---------------- scoreboard monitor: decodes TX into rx_q ----------------
    initial begin
        forever begin
            tick();
            if (mon_en && TX === 1'b0) begin
                logic [7:0] r;
                repeat (mon_div + mon_div / 2) tick();
                r[0] = TX;
                for (int k = 1; k < 8; k++) begin
                    repeat (mon_div) tick();
                    r[k] = TX;
                end
                repeat (mon_div) tick();
                if (TX !== 1'b1) frame_errs++;
                rx_q.push_back(r);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] s;
        int          n;
        bit          tmo;

        // Reset, with a write presented while reset is held.
        repeat (3) tick();
        IOBUS_ADDR = ADDR_TXDATA;
        IOBUS_OUT  = 32'h77;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = '0;
        RST = 1'b1;
        repeat (2) tick();
        check("rst_tx", TX, 1'b1);
        check("rst_busy", TX_BUSY, 1'b0);
        check_reg("rst_status", ADDR_STATUS, 32'h0000_0002);
        check_reg("rst_bauddiv", ADDR_BAUDDIV, 32'd868);

        // Basic frame: 0x55 at divisor 4.
        io_write(ADDR_BAUDDIV, 32'd4);
        check_reg("baud4_rb", ADDR_BAUDDIV, 32'd4);
        io_write(ADDR_TXDATA, 32'hFFFF_FF55);
        check("basic_n1_tx", TX, 1'b1);
        check("basic_n1_busy", TX_BUSY, 1'b1);
        check_reg("basic_n1_status", ADDR_STATUS, 32'h0000_0010);
        tick();
        check_frame(8'h55, 4, "basic", 1'b0, '0, '0, 0);
        check("basic_end_tx", TX, 1'b1);
        check("basic_end_busy", TX_BUSY, 1'b0);
        check_reg("basic_end_status", ADDR_STATUS, 32'h0000_0002);

        // Overflow: keep the line busy with 0xC3 so nothing pops while 9 bytes arrive.
        io_write(ADDR_BAUDDIV, 32'd16);
        io_write(ADDR_TXDATA, 32'hC3);
        tick();
        tick();
        for (int i = 0; i < 9; i++) io_write(ADDR_TXDATA, 32'(i));
        check_reg("ovf_status", ADDR_STATUS, 32'h0000_008D);
        io_write(32'h1100_0045, 32'h8);
        check_reg("ovf_after_0x45", ADDR_STATUS, 32'h0000_008D);
        io_write(ADDR_STATUS, 32'hFFFF_FFF7);
        check_reg("ovf_keep_bit3_0", ADDR_STATUS, 32'h0000_008D);
        io_write(ADDR_STATUS, 32'h8);
        check_reg("ovf_cleared", ADDR_STATUS, 32'h0000_0085);
        wait_line_idle("ovf_wait_prime");
        tick();
        for (int i = 0; i < 8; i++) begin
            check_frame(8'(i), 16, $sformatf("ovf_byte%0d", i), 1'b0, '0, '0, 0);
            check($sformatf("ovf_gap_tx%0d", i), TX, 1'b1);
            check_reg($sformatf("ovf_gap_status%0d", i), ADDR_STATUS,
                      32'((7 - i) << 4) | ((i == 7) ? 32'h2 : 32'h0));
            if (i < 7) tick();
        end
        check("ovf_end_busy", TX_BUSY, 1'b0);

        // Divisor clamp and upper-bit masking.
        io_write(ADDR_BAUDDIV, 32'd0);
        check_reg("clamp0", ADDR_BAUDDIV, 32'd2);
        io_write(ADDR_BAUDDIV, 32'd1);
        check_reg("clamp1", ADDR_BAUDDIV, 32'd2);
        io_write(ADDR_BAUDDIV, 32'hABCD_0003);
        check_reg("baud_mask", ADDR_BAUDDIV, 32'd3);

        // Mid-frame divisor change: 8 -> 3 during the first of two frames.
        io_write(ADDR_BAUDDIV, 32'd8);
        io_write(ADDR_TXDATA, 32'h3C);
        io_write(ADDR_TXDATA, 32'hA5);
        check_frame(8'h3C, 8, "div8", 1'b1, ADDR_BAUDDIV, 32'd3, 4);
        check("div_gap_tx", TX, 1'b1);
        check_reg("div3_rb", ADDR_BAUDDIV, 32'd3);
        tick();
        check_frame(8'hA5, 3, "div3", 1'b0, '0, '0, 0);
        check_reg("div_end_status", ADDR_STATUS, 32'h0000_0002);

        // Reset during DATA bit 3 with three bytes queued.
        io_write(ADDR_BAUDDIV, 32'd8);
        io_write(ADDR_TXDATA, 32'h11);
        io_write(ADDR_TXDATA, 32'h22);
        io_write(ADDR_TXDATA, 32'h33);
        io_write(ADDR_TXDATA, 32'h44);
        check_reg("mid_status", ADDR_STATUS, 32'h0000_0034);
        repeat (32) tick();
        check("mid_bit3_tx", TX, 1'b0);
        RST = 1'b0;
        tick();
        check("mid_rst_tx", TX, 1'b1);
        check("mid_rst_busy", TX_BUSY, 1'b0);
        check_reg("mid_rst_status", ADDR_STATUS, 32'h0000_0002);
        check_reg("mid_rst_bauddiv", ADDR_BAUDDIV, 32'd868);
        RST = 1'b1;
        repeat (5) tick();
        check("post_rst_tx", TX, 1'b1);
        check_reg("post_rst_status", ADDR_STATUS, 32'h0000_0002);

        // Address decode uses all 32 bits.
        check_reg("dec_0x50", 32'h1100_0050, 32'h0);
        check_reg("dec_alias44", 32'h0000_0044, 32'h0);
        io_write(32'h1100_0041, 32'h5A);
        check_reg("dec_txdata_near", ADDR_STATUS, 32'h0000_0002);
        io_write(32'h1100_0049, 32'd3);
        check_reg("dec_baud_near", ADDR_BAUDDIV, 32'd868);

        // FIFO wrap: stream 20 bytes with software polling of full.
        io_write(ADDR_BAUDDIV, 32'd2);
        mon_div = 2;
        mon_en  = 1'b1;
        tmo     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] v;
            v = 8'hA0 + 8'(i);
            n = 0;
            io_read(ADDR_STATUS, s);
            while (s[ST_FULL] && n < 500) begin
                tick();
                n++;
                io_read(ADDR_STATUS, s);
            end
            if (n >= 500) tmo = 1'b1;
            io_write(ADDR_TXDATA, 32'(v));
            exp_q.push_back(v);
        end
        n = 0;
        while ((TX_BUSY || rx_q.size() < 20) && n < 2000) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("wrap_poll_tmo", tmo, 1'b0);
        check("wrap_rx_count", rx_q.size(), 20);
        check("wrap_frame_errs", frame_errs, 0);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] e;
            logic [7:0] r;
            e = exp_q.pop_front();
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check($sformatf("wrap_byte%0d", i), r, e);
        end
        check_reg("wrap_end_status", ADDR_STATUS, 32'h0000_0002);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iobus_uart_tx.md
IOBUS_UART_TX -- requirements
Module: iobus_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX FIFO entries; SHALL be a power of two, range 2..64.
REQ-002 Parameter BAUD_DIV_RST, default 868, reset value of the baud divisor in clock cycles per bit.
REQ-003 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 RST  input  1  reset; synchronous, active-low.
REQ-005 IOBUS_ADDR  input  32  CPU IO address, byte granular.
REQ-006 IOBUS_OUT  input  32  CPU IO write data.
REQ-007 IOBUS_WR  input  1  CPU IO write strobe, one cycle per store.
REQ-008 IOBUS_IN  output  32  read data back to the CPU.
REQ-009 TX  output  1  UART serial output, idle high.
REQ-010 TX_BUSY  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-011 Register map: 0x1100_0040 TXDATA (write), 0x1100_0044 STATUS (read/write), 0x1100_0048 BAUDDIV (read/write); address decode SHALL use the full 32 bits.
REQ-012 A write to TXDATA SHALL push IOBUS_OUT[7:0] into the FIFO; bits [31:8] are ignored.
REQ-013 A push SHALL be accepted when count < FIFO_DEPTH, or when count = FIFO_DEPTH and a pop occurs in the same cycle.
REQ-014 A push that is not accepted SHALL be dropped and SHALL set sticky STATUS.OVF.
REQ-015 STATUS read format: [0] full, [1] empty, [2] line busy (FSM not IDLE), [3] OVF, [10:4] count, all other bits 0.
REQ-016 A write to STATUS with IOBUS_OUT[3]=1 SHALL clear OVF; if an overflowing push occurs in the same cycle, the set SHALL win.
REQ-017 A write to BAUDDIV SHALL load IOBUS_OUT[15:0]; a written value of 0 or 1 SHALL be stored as 2.
REQ-018 A BAUDDIV read SHALL return {16'b0, divisor}.
REQ-019 IOBUS_IN SHALL be combinational from IOBUS_ADDR and SHALL be 0 for any unmapped address, so that the top level can OR it with other peripherals.
REQ-020 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-021 IDLE: TX = 1; if the FIFO is non-empty, pop one byte into the shift register, latch the divisor, and go to START.
REQ-022 START: TX = 0 for exactly one bit time, then go to DATA.
REQ-023 DATA: transmit 8 bits LSB first, one bit time each, using a 3-bit bit index, then go to STOP.
REQ-024 STOP: TX = 1 for one bit time, then go to IDLE.
REQ-025 One bit time SHALL be exactly divisor cycles, and one frame SHALL be exactly 10 × divisor cycles.
REQ-026 The divisor SHALL be latched only at the IDLE-to-START transition; a BAUDDIV write mid-frame SHALL take effect from the next frame.
REQ-027 TX SHALL be driven from a flop.
REQ-028 Latency: a TXDATA write in cycle N to an empty FIFO with the FSM idle SHALL pop in cycle N+1 and drive TX low from cycle N+2.
REQ-029 For back-to-back frames with a non-empty FIFO, the next START SHALL begin one cycle after STOP ends; that one cycle is the IDLE pop cycle with TX = 1.
REQ-030 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL be a separate counter of width log2(FIFO_DEPTH)+1.

Reset
REQ-031 On a clock edge with RST = 0, the block SHALL reset to: FSM = IDLE, TX = 1, TX_BUSY = 0, FIFO pointers and count = 0, OVF = 0, divisor = BAUD_DIV_RST, shift register, bit index and baud counter = 0.
REQ-032 Reset mid-frame SHALL abort the frame, drive TX = 1 on the next cycle, and discard all FIFO contents.
REQ-033 Writes presented while RST = 0 SHALL be ignored.

Structure
REQ-034 Package iobus_pkg SHALL hold the three register addresses, the STATUS bit positions, and the FSM state enum type.
REQ-035 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width 8 and FIFO_DEPTH, with push, pop, full, empty and count ports.
REQ-036 The serializer FSM, register decode and read mux SHALL reside in iobus_uart_tx.

Verification
REQ-037 Basic frame: set BAUDDIV = 4, write TXDATA = 0x55 → TX low at N+2; bits 1,0,1,0,1,0,1,0 at 4 cycles each; stop high; 40 cycles total.
REQ-038 Overflow: with BAUDDIV = 16, write 9 bytes 0x00..0x08 back-to-back → STATUS = full, count = 8, OVF = 1; bytes 0x00..0x07 transmitted in order, 0x08 never appears.
REQ-039 Set/clear race: write STATUS = 0x8 in the same cycle as an overflowing push → OVF stays 1; a later STATUS = 0x8 write alone → OVF = 0.
REQ-040 Divisor change and clamp: write BAUDDIV = 0 → reads back 2; change BAUDDIV from 8 to 3 mid-frame → current frame stays at 80 cycles, next frame takes 30 cycles.
REQ-041 Reset mid-frame: pull RST low during DATA bit 3 with 3 bytes queued → next cycle TX = 1, TX_BUSY = 0, STATUS reads 0x2, BAUDDIV reads 868.
REQ-042 Decode and FIFO wrap: reading 0x1100_0050 or 0x0000_0044 returns 0, and a write to 0x1100_0045 has no effect; 20 bytes 0xA0..0xB3 streamed with software polling of full → all transmitted in order across pointer wrap.
